id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core.
- Captures the main-decoder control bundle (ALUOp, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, store_or_not) together with operand data and register addresses from ID, and presents them to EX one cycle later.
- Integrates load-use hazard detection: a bubble is inserted here and upstream (PC, IF/ID) is told to hold.
- Handles branch flush and global memory freeze, and counts inserted bubbles.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/id_ex_stage_reg_if.sv | 39 +++
 rtl/id_ex_stage_reg_load_use_detect.sv | 24 ++
 rtl/id_ex_stage_reg.sv | 121 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: ALUOp encodings, opcodes, and the main-decoder
// control bundle that travels down the pipeline.
package cpu_pkg;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int CTRL_W = 8;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       store;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Main-decoder control bundle for an opcode; unknown opcodes decode to a bubble.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = CTRL_BUBBLE;
        case (opcode)
            OPC_R:      begin c.reg_write = 1'b1; c.alu_op = ALUOP_R; end
            OPC_I:      begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALUOP_I; end
            OPC_LOAD:   begin
                c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.mem_read = 1'b1;
                c.alu_src = 1'b1; c.alu_op = ALUOP_ADD;
            end
            OPC_STORE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.store = 1'b1; c.alu_op = ALUOP_ADD; end
            OPC_BRANCH: c.alu_op = ALUOP_BR;
            default:    c = CTRL_BUBBLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID->EX bundle: ID-side inputs (*_i) and registered EX-side view (*_o).
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              valid_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, store_or_not_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] RS1data_i, RS2data_i, Imm_i;
    logic [9:0]        funct_i;
    logic [REG_AW-1:0] RS1addr_i, RS2addr_i, RDaddr_i;
    logic              flush_i, freeze_i;

    logic              valid_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, store_or_not_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] RS1data_o, RS2data_o, Imm_o;
    logic [9:0]        funct_o;
    logic [REG_AW-1:0] RS1addr_o, RS2addr_o, RDaddr_o;
    logic              stall_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output valid_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, store_or_not_i,
               ALUOp_i, RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
               flush_i, freeze_i,
        input  valid_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, store_or_not_o,
               ALUOp_o, RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
               stall_o, bubble_cnt_o
    );

    modport slave (
        input  valid_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i, ALUSrc_i, store_or_not_i,
               ALUOp_i, RS1data_i, RS2data_i, Imm_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
               flush_i, freeze_i,
        output valid_o, RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, ALUSrc_o, store_or_not_o,
               ALUOp_o, RS1data_o, RS2data_o, Imm_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
               stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard: the load now in EX targets a register the ID instruction reads.
module load_use_detect
    import cpu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              id_valid_i,
    input  logic              id_alu_src_i,
    input  logic              id_store_i,
    input  logic [1:0]        id_alu_op_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              ex_valid_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    output logic              hazard_o
);
    logic use_rs2;

    // An I-type reuses the rs2 field for immediate bits, so only real rs2 readers count.
    assign use_rs2  = ~id_alu_src_i | id_store_i | (id_alu_op_i == ALUOP_BR);
    assign hazard_o = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) &
                      ((ex_rd_i == id_rs1_i) | (use_rs2 & (ex_rd_i == id_rs2_i)));
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, freeze and a
// saturating bubble counter.
module id_ex_stage_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic   clk_i,
    input logic   rst_i,
    id_ex_if.slave bus
);
    ctrl_t             in_ctrl, ctrl_d, ctrl_q;
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] rs1data_d, rs1data_q, rs2data_d, rs2data_q, imm_d, imm_q;
    logic [9:0]        funct_d, funct_q;
    logic [REG_AW-1:0] rs1addr_d, rs1addr_q, rs2addr_d, rs2addr_q, rdaddr_d, rdaddr_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              hazard, stall;

    assign in_ctrl = '{reg_write: bus.RegWrite_i, mem_to_reg: bus.MemToReg_i, mem_read: bus.MemRead_i,
                       mem_write: bus.MemWrite_i, alu_src: bus.ALUSrc_i, store: bus.store_or_not_i,
                       alu_op: bus.ALUOp_i};

    load_use_detect #(.REG_AW(REG_AW)) u_detect (
        .id_valid_i   (bus.valid_i),
        .id_alu_src_i (bus.ALUSrc_i),
        .id_store_i   (bus.store_or_not_i),
        .id_alu_op_i  (bus.ALUOp_i),
        .id_rs1_i     (bus.RS1addr_i),
        .id_rs2_i     (bus.RS2addr_i),
        .ex_valid_i   (valid_q),
        .ex_mem_read_i(ctrl_q.mem_read),
        .ex_rd_i      (rdaddr_q),
        .hazard_o     (hazard)
    );

    assign stall = hazard & ~bus.flush_i & ~bus.freeze_i;

    always_comb begin
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        rs1data_d = rs1data_q;
        rs2data_d = rs2data_q;
        imm_d     = imm_q;
        funct_d   = funct_q;
        rs1addr_d = rs1addr_q;
        rs2addr_d = rs2addr_q;
        rdaddr_d  = rdaddr_q;
        cnt_d     = cnt_q;
        if (bus.freeze_i) begin
            // hold everything
        end else if (bus.flush_i || stall) begin
            ctrl_d    = CTRL_BUBBLE;
            valid_d   = 1'b0;
            rs1data_d = '0;
            rs2data_d = '0;
            imm_d     = '0;
            funct_d   = '0;
            rs1addr_d = '0;
            rs2addr_d = '0;
            rdaddr_d  = '0;
            if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
            ctrl_d    = bus.valid_i ? in_ctrl : CTRL_BUBBLE;
            valid_d   = bus.valid_i;
            rs1data_d = bus.RS1data_i;
            rs2data_d = bus.RS2data_i;
            imm_d     = bus.Imm_i;
            funct_d   = bus.funct_i;
            rs1addr_d = bus.RS1addr_i;
            rs2addr_d = bus.RS2addr_i;
            rdaddr_d  = bus.RDaddr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctrl_q    <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            rs1data_q <= '0;
            rs2data_q <= '0;
            imm_q     <= '0;
            funct_q   <= '0;
            rs1addr_q <= '0;
            rs2addr_q <= '0;
            rdaddr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            rs1data_q <= rs1data_d;
            rs2data_q <= rs2data_d;
            imm_q     <= imm_d;
            funct_q   <= funct_d;
            rs1addr_q <= rs1addr_d;
            rs2addr_q <= rs2addr_d;
            rdaddr_q  <= rdaddr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.valid_o        = valid_q;
    assign bus.RegWrite_o     = ctrl_q.reg_write;
    assign bus.MemToReg_o     = ctrl_q.mem_to_reg;
    assign bus.MemRead_o      = ctrl_q.mem_read;
    assign bus.MemWrite_o     = ctrl_q.mem_write;
    assign bus.ALUSrc_o       = ctrl_q.alu_src;
    assign bus.store_or_not_o = ctrl_q.store;
    assign bus.ALUOp_o        = ctrl_q.alu_op;
    assign bus.RS1data_o      = rs1data_q;
    assign bus.RS2data_o      = rs2data_q;
    assign bus.Imm_o          = imm_q;
    assign bus.funct_o        = funct_q;
    assign bus.RS1addr_o      = rs1addr_q;
    assign bus.RS2addr_o      = rs2addr_q;
    assign bus.RDaddr_o       = rdaddr_q;
    assign bus.stall_o        = stall;
    assign bus.bubble_cnt_o   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg (CNT_W=4 so counter saturation is reachable).
module tb_id_ex_stage_reg;
    import cpu_pkg::*;

    localparam int DW = 32, AW = 5, CW = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();
    id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

    typedef struct packed {
        logic          v;
        ctrl_t         ctrl;
        logic [DW-1:0] r1, r2, imm;
        logic [9:0]    fn;
        logic [AW-1:0] a1, a2, rd;
        logic [CW-1:0] cnt;
    } out_t;

    typedef struct {
        logic          v;
        ctrl_t         ctrl;
        logic [DW-1:0] r1, r2, imm;
        logic [AW-1:0] a1, a2, rd;
        logic          fl, fz;
        logic          ex_stall, ex_bub;
        int            ex_cnt;
    } vec_t;

    int checks = 0, errors = 0;
    out_t exp_q[$];
    out_t last_exp;
    vec_t tbl[22];

    function automatic vec_t mk(input logic v, input logic [6:0] op, input int r1, input int r2, input int imm,
                                input int a1, input int a2, input int rd, input logic fl, input logic fz,
                                input logic st, input logic bub, input int cnt);
        vec_t t;
        t.v = v; t.ctrl = decode_ctrl(op); t.r1 = r1; t.r2 = r2; t.imm = imm;
        t.a1 = a1[AW-1:0]; t.a2 = a2[AW-1:0]; t.rd = rd[AW-1:0];
        t.fl = fl; t.fz = fz; t.ex_stall = st; t.ex_bub = bub; t.ex_cnt = cnt;
        return t;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.v = bus.valid_o;
        o.ctrl = '{reg_write: bus.RegWrite_o, mem_to_reg: bus.MemToReg_o, mem_read: bus.MemRead_o,
                   mem_write: bus.MemWrite_o, alu_src: bus.ALUSrc_o, store: bus.store_or_not_o,
                   alu_op: bus.ALUOp_o};
        o.r1 = bus.RS1data_o; o.r2 = bus.RS2data_o; o.imm = bus.Imm_o; o.fn = bus.funct_o;
        o.a1 = bus.RS1addr_o; o.a2 = bus.RS2addr_o; o.rd = bus.RDaddr_o; o.cnt = bus.bubble_cnt_o;
        return o;
    endfunction

    task automatic check_stall(input string name, input logic exp);
        checks++;
        if (bus.stall_o !== exp) begin
            errors++;
            $display("FAIL %s stall_o: got %b want %b", name, bus.stall_o, exp);
        end
    endtask

    task automatic check_out(input string name, input out_t exp);
        out_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s outputs: got %h want %h", name, got, exp);
        end
    endtask

    task automatic apply(input string name, input vec_t t);
        out_t e;
        @(negedge clk);
        bus.valid_i = t.v;
        {bus.RegWrite_i, bus.MemToReg_i, bus.MemRead_i, bus.MemWrite_i, bus.ALUSrc_i,
         bus.store_or_not_i, bus.ALUOp_i} = t.ctrl;
        bus.RS1data_i = t.r1; bus.RS2data_i = t.r2; bus.Imm_i = t.imm;
        bus.funct_i = t.imm[9:0] ^ 10'h155;
        bus.RS1addr_i = t.a1; bus.RS2addr_i = t.a2; bus.RDaddr_i = t.rd;
        bus.flush_i = t.fl; bus.freeze_i = t.fz;
        #1 check_stall(name, t.ex_stall);
        if (t.fz) e = last_exp;
        else if (t.ex_bub) begin
            e = '0; e.cnt = t.ex_cnt[CW-1:0];
        end else begin
            e.v = t.v; e.ctrl = t.v ? t.ctrl : CTRL_BUBBLE;
            e.r1 = t.r1; e.r2 = t.r2; e.imm = t.imm; e.fn = t.imm[9:0] ^ 10'h155;
            e.a1 = t.a1; e.a2 = t.a2; e.rd = t.rd; e.cnt = t.ex_cnt[CW-1:0];
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL %s scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check_out(name, e);
            last_exp = e;
        end
    endtask

    initial begin
        int c;
        bus.valid_i = 0; bus.RegWrite_i = 0; bus.MemToReg_i = 0; bus.MemRead_i = 0; bus.MemWrite_i = 0;
        bus.ALUSrc_i = 0; bus.store_or_not_i = 0; bus.ALUOp_i = 0; bus.RS1data_i = 0; bus.RS2data_i = 0;
        bus.Imm_i = 0; bus.funct_i = 0; bus.RS1addr_i = 0; bus.RS2addr_i = 0; bus.RDaddr_i = 0;
        bus.flush_i = 0; bus.freeze_i = 0;

        //               v  op          r1  r2  imm a1 a2 rd fl fz st bub cnt
        tbl[0]  = mk(1, OPC_R,      5,  7,  0,  1, 2, 3, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, OPC_LOAD,   9,  0,  8,  1, 0, 5, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, OPC_R,     11, 12,  0,  5, 6, 7, 0, 0, 1, 1, 1);
        tbl[3]  = mk(1, OPC_R,     11, 12,  0,  5, 6, 7, 0, 0, 0, 0, 1);
        tbl[4]  = mk(1, OPC_LOAD,   9,  0,  8,  1, 0, 5, 0, 0, 0, 0, 1);
        tbl[5]  = mk(1, OPC_I,      3,  0,  5,  2, 5, 8, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, OPC_LOAD,   9,  0,  8,  1, 0, 5, 0, 0, 0, 0, 1);
        tbl[7]  = mk(1, OPC_STORE, 13, 14, 4,  2, 5, 0, 0, 0, 1, 1, 2);
        tbl[8]  = mk(1, OPC_STORE, 13, 14, 4,  2, 5, 0, 0, 0, 0, 0, 2);
        tbl[9]  = mk(1, OPC_LOAD,   9,  0,  8,  1, 0, 0, 0, 0, 0, 0, 2);
        tbl[10] = mk(1, OPC_R,     15, 16, 0,  0, 0, 9, 0, 0, 0, 0, 2);
        tbl[11] = mk(1, OPC_LOAD,   9,  0,  8,  1, 0, 5, 0, 0, 0, 0, 2);
        tbl[12] = mk(1, OPC_R,     17, 18, 0,  5, 6, 7, 1, 0, 0, 1, 2);
        tbl[13] = mk(1, OPC_LOAD,  19,  0, 12, 1, 0, 5, 0, 0, 0, 0, 2);
        tbl[14] = mk(1, OPC_R,     20, 21, 0,  5, 6, 7, 0, 1, 0, 0, 2);
        tbl[15] = mk(1, OPC_I,     22, 23, 1,  5, 1, 4, 0, 1, 0, 0, 2);
        tbl[16] = mk(0, OPC_STORE, 24, 25, 2,  5, 5, 2, 0, 1, 0, 0, 2);
        tbl[17] = mk(1, OPC_R,     26, 27, 0,  5, 6, 7, 0, 0, 1, 1, 3);
        tbl[18] = mk(1, OPC_R,     26, 27, 0,  5, 6, 7, 0, 0, 0, 0, 3);
        tbl[19] = mk(0, OPC_LOAD,  28,  0, 3,  1, 0, 6, 0, 0, 0, 0, 3);
        tbl[20] = mk(1, OPC_LOAD,  29,  0, 4,  1, 0, 5, 0, 0, 0, 0, 3);
        tbl[21] = mk(0, OPC_R,     30, 31, 0,  5, 6, 7, 0, 0, 0, 0, 3);

        last_exp = '0;
        repeat (2) @(posedge clk);
        #1 check_out("reset", '0);
        check_stall("reset", 1'b0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 22; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // reset while a load-use stall is being signalled
        apply("mid_lw", mk(1, OPC_LOAD, 9, 0, 8, 1, 0, 5, 0, 0, 0, 0, 3));
        @(negedge clk);
        {bus.RegWrite_i, bus.MemToReg_i, bus.MemRead_i, bus.MemWrite_i, bus.ALUSrc_i,
         bus.store_or_not_i, bus.ALUOp_i} = decode_ctrl(OPC_R);
        bus.valid_i = 1; bus.RS1addr_i = 5; bus.RS2addr_i = 6; bus.RDaddr_i = 7;
        #1 check_stall("mid_pre", 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check_out("mid_rst", '0);
        check_stall("mid_rst", 1'b0);
        @(negedge clk) rst_n = 1'b1;
        last_exp = '0;

        // repeated load-use pairs drive the counter into saturation
        c = 0;
        for (int k = 0; k < 20; k++) begin
            apply("sat_lw", mk(1, OPC_LOAD, k, 0, 8, 1, 0, 5, 0, 0, 0, 0, c));
            c = (c < 15) ? c + 1 : 15;
            apply($sformatf("sat%0d", k), mk(1, OPC_R, k, k + 1, 0, 5, 6, 7, 0, 0, 1, 1, c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
